// File: rtl/seq_div_u16_u8.sv
// Unsigned restoring divider, DW_A-bit dividend by DW_B-bit divisor, one quotient bit per clock.
// Latency DW_A+1 cycles from accept to out_valid; results hold in DONE until out_ready.
module seq_div_u16_u8 #(
  parameter int DW_A = 16,
  parameter int DW_B = 8,
  parameter int CW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW_A-1:0] dividend,
  input  logic [DW_B-1:0] divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_A-1:0] quotient,
  output logic [DW_B-1:0] remainder,
  output logic            div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [DW_B:0]   pr;
  logic [DW_A-1:0] sreg;
  logic [DW_B-1:0] div;
  logic [CW-1:0]   cnt;
  logic            dbz;

  logic [DW_B:0]   t;
  logic [DW_B:0]   t_sub;
  logic            qbit;
  logic            fin;

  // pr's top bit is always 0 after a restoring step, so dropping it here loses nothing.
  always_comb begin
    t     = (DW_B+1)'({pr, sreg[DW_A-1]});
    qbit  = (t >= {1'b0, div});
    t_sub = t - {1'b0, div};
    // The counter wraps to all ones after the final step; that value marks the finalise cycle.
    fin   = (cnt == {CW{1'b1}});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (fin)       state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr          <= '0;
      sreg        <= '0;
      div         <= '0;
      cnt         <= '0;
      dbz         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (!flush) begin
      if (state == IDLE && in_valid) begin
        sreg <= dividend;
        div  <= divisor;
        pr   <= '0;
        cnt  <= CW'(DW_A-1);
        dbz  <= (divisor == '0);
      end else if (state == RUN) begin
        if (fin) begin
          // A zero divisor naturally yields all-ones quotient and dividend low bits as remainder.
          quotient    <= sreg;
          remainder   <= pr[DW_B-1:0];
          div_by_zero <= dbz;
        end else begin
          pr   <= qbit ? t_sub : t;
          sreg <= {sreg[DW_A-2:0], qbit};
          cnt  <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_div_u16_u8.sv
// Directed-vector bench for seq_div_u16_u8: latency, corner quotients, divide by zero,
// backpressure, flush, mid-run reset and a short random sweep.
module tb_seq_div_u16_u8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int tests;
  int fails;

  seq_div_u16_u8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one edge, then count edges until out_valid (bounded).
  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv, output int lat);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (quotient !== 16'd0) begin fails++; $display("FAIL reset_quotient got %0d want 0", quotient); end
    tests++; if (remainder !== 8'd0) begin fails++; $display("FAIL reset_remainder got %0d want 0", remainder); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(16'd1000, 8'd7, lat);
    tests++; if (lat !== 17) begin fails++; $display("FAIL basic_latency got %0d want 17", lat); end
    tests++; if (quotient !== 16'd142) begin fails++; $display("FAIL basic_quotient got %0d want 142", quotient); end
    tests++; if (remainder !== 8'd6) begin fails++; $display("FAIL basic_remainder got %0d want 6", remainder); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
    handshake();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready_after got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_out_valid_after got %b want 0", out_valid); end
  endtask

  task automatic test_extremes();
    int lat;
    run_op(16'hFFFF, 8'hFF, lat);
    tests++; if (lat !== 17) begin fails++; $display("FAIL ext1_latency got %0d want 17", lat); end
    tests++; if (quotient !== 16'h0101) begin fails++; $display("FAIL ext1_quotient got %h want 0101", quotient); end
    tests++; if (remainder !== 8'h00) begin fails++; $display("FAIL ext1_remainder got %h want 00", remainder); end
    handshake();
    run_op(16'hFFFF, 8'h01, lat);
    tests++; if (quotient !== 16'hFFFF) begin fails++; $display("FAIL ext2_quotient got %h want ffff", quotient); end
    tests++; if (remainder !== 8'h00) begin fails++; $display("FAIL ext2_remainder got %h want 00", remainder); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL ext2_dbz got %b want 0", div_by_zero); end
    handshake();
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(16'h1234, 8'h00, lat);
    tests++; if (lat !== 17) begin fails++; $display("FAIL dz_latency got %0d want 17", lat); end
    tests++; if (quotient !== 16'hFFFF) begin fails++; $display("FAIL dz_quotient got %h want ffff", quotient); end
    tests++; if (remainder !== 8'h34) begin fails++; $display("FAIL dz_remainder got %h want 34", remainder); end
    tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'd200, 8'd9, lat);
    tests++; if (lat !== 17) begin fails++; $display("FAIL bp_latency got %0d want 17", lat); end
    // A new request is held high while the result is stalled.
    dividend = 16'd50;
    divisor  = 8'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1 || quotient !== 16'd22 || remainder !== 8'd2 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc %0d got v=%b q=%0d r=%0d rdy=%b want v=1 q=22 r=2 rdy=0",
                 i, out_valid, quotient, remainder, in_ready);
      end
    end
    handshake();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_idle_after_hs got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_second_accept got in_ready=%b want 0", in_ready); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++; if (lat !== 17) begin fails++; $display("FAIL bp2_latency got %0d want 17", lat); end
    tests++; if (quotient !== 16'd10 || remainder !== 8'd0) begin
      fails++; $display("FAIL bp2_result got q=%0d r=%0d want q=10 r=0", quotient, remainder);
    end
    handshake();
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    dividend = 16'd5000;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL flush_no_result got out_valid seen=%b want 0", seen); end
    // flush wins over a simultaneous accept
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_blocks_accept got in_ready=%b want 1", in_ready); end
    run_op(16'd5000, 8'd3, lat);
    tests++; if (lat !== 17) begin fails++; $display("FAIL flush_rerun_latency got %0d want 17", lat); end
    tests++; if (quotient !== 16'd1666 || remainder !== 8'd2) begin
      fails++; $display("FAIL flush_rerun_result got q=%0d r=%0d want q=1666 r=2", quotient, remainder);
    end
    handshake();
  endtask

  task automatic test_mid_reset();
    int lat;
    dividend = 16'd100;
    divisor  = 8'd10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_hs got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
    tests++; if (quotient !== 16'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL rst_data got q=%0d r=%0d z=%b want 0 0 0", quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_held got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'd100, 8'd10, lat);
    tests++; if (lat !== 17 || quotient !== 16'd10 || remainder !== 8'd0) begin
      fails++; $display("FAIL rst_rerun got lat=%0d q=%0d r=%0d want 17 10 0", lat, quotient, remainder);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    int dd;
    int dv;
    for (int i = 0; i < 300; i++) begin
      dd = $urandom_range(0, 65535);
      dv = $urandom_range(1, 255);
      run_op(16'(dd), 8'(dv), lat);
      tests++;
      if (lat !== 17 || int'(quotient) !== dd / dv || int'(remainder) !== dd % dv || div_by_zero !== 1'b0
          || int'(quotient) * dv + int'(remainder) !== dd || int'(remainder) >= dv) begin
        fails++;
        $display("FAIL rand %0d/%0d got lat=%0d q=%0d r=%0d z=%b want lat=17 q=%0d r=%0d z=0",
                 dd, dv, lat, quotient, remainder, div_by_zero, dd / dv, dd % dv);
      end
      handshake();
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_flush();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
